// File: rtl/dma_pkg.sv
// Shared definitions for the DMA controller: FSM state encoding, slave register map, CTRL bits.
package dma_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_READ,
        ST_WRITE,
        ST_DONE,
        ST_REL
    } state_t;

    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_SIZE = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START   = 0;
    localparam int CTRL_IRQ_CLR = 1;

endpackage

// File: rtl/dma_regs.sv
// DMA slave register file: SRC/DST/SIZE programming gated by busy, START strobe,
// combinational readback and the level interrupt flag.
module dma_regs
    import dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [1:0]        s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    input  logic              busy_i,
    input  logic              irq_set_i,
    output logic              start_o,
    output logic [ADDR_W-1:0] src_o,
    output logic [ADDR_W-1:0] dst_o,
    output logic [CNT_W-1:0]  size_o,
    output logic              irq_o
);

    logic [ADDR_W-1:0] src_q;
    logic [ADDR_W-1:0] dst_q;
    logic [CNT_W-1:0]  size_q;
    logic              irq_q;
    logic              wr_en;
    logic              ctrl_wr;
    logic              unused_din;

    assign wr_en      = s_sel & s_wr;
    assign ctrl_wr    = wr_en & (s_addr == REG_CTRL);
    assign start_o    = ctrl_wr & ~busy_i & s_din[CTRL_START];
    assign unused_din = ^s_din;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src_q  <= '0;
            dst_q  <= '0;
            size_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (wr_en && !busy_i) begin
                case (s_addr)
                    REG_SRC:  src_q  <= s_din[ADDR_W-1:0];
                    REG_DST:  dst_q  <= s_din[ADDR_W-1:0];
                    REG_SIZE: size_q <= s_din[CNT_W-1:0];
                    default:  ;
                endcase
            end
            // A completion in the same cycle as a clear must not be lost.
            if (irq_set_i) begin
                irq_q <= 1'b1;
            end else if (ctrl_wr && s_din[CTRL_IRQ_CLR]) begin
                irq_q <= 1'b0;
            end
        end
    end

    always_comb begin
        s_dout = '0;
        case (s_addr)
            REG_SRC:  s_dout = DATA_W'(src_q);
            REG_DST:  s_dout = DATA_W'(dst_q);
            REG_SIZE: s_dout = DATA_W'(size_q);
            default:  s_dout = DATA_W'({busy_i, irq_q});
        endcase
    end

    assign src_o  = src_q;
    assign dst_o  = dst_q;
    assign size_o = size_q;
    assign irq_o  = irq_q;

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel DMA controller (bus master 1): word-by-word read/write copy with level interrupt.
// Optional DMA_CTRL_RELEASE_EN: drop the bus request for one cycle between words.
module dma_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [1:0]        s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din,
    output logic              busy,
    output logic              interrupt
);

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [DATA_W-1:0] buf_q;
    logic              start;
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [CNT_W-1:0]  size;

    assign busy = (state_q != ST_IDLE);

    dma_regs #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .CNT_W (CNT_W)
    ) u_regs (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_sel    (s_sel),
        .s_wr     (s_wr),
        .s_addr   (s_addr),
        .s_din    (s_din),
        .s_dout   (s_dout),
        .busy_i   (busy),
        .irq_set_i(state_q == ST_DONE),
        .start_o  (start),
        .src_o    (src),
        .dst_o    (dst),
        .size_o   (size),
        .irq_o    (interrupt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            buf_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        cnt_q   <= '0;
                        state_q <= (size == '0) ? ST_DONE : ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (m_grant) state_q <= ST_READ;
                end
                ST_READ: begin
                    if (m_grant) begin
                        buf_q   <= m_din;
                        state_q <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (m_grant) begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (cnt_q == size - CNT_W'(1)) begin
                            state_q <= ST_DONE;
                        end else begin
`ifdef DMA_CTRL_RELEASE_EN
                            state_q <= ST_REL;
`else
                            state_q <= ST_READ;
`endif
                        end
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                ST_REL:  state_q <= ST_REQ;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign m_req  = (state_q == ST_REQ) || (state_q == ST_READ) || (state_q == ST_WRITE);
    // Losing the grant mid-WRITE must never produce a bus write.
    assign m_wr   = (state_q == ST_WRITE) && m_grant;
    assign m_dout = buf_q;

    always_comb begin
        m_addr = '0;
        if (state_q == ST_READ) begin
            m_addr = src + ADDR_W'(cnt_q);
        end else if (state_q == ST_WRITE) begin
            m_addr = dst + ADDR_W'(cnt_q);
        end
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// Scoreboard bench for dma_ctrl: expected bus writes are queued at START and
// matched by a monitor against every granted write the DUT issues.
`timescale 1ns/1ps
module tb_dma_ctrl;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_sel, s_wr;
    logic [1:0]  s_addr;
    logic [31:0] s_din, s_dout;
    logic        m_req, m_grant, m_wr;
    logic [15:0] m_addr;
    logic [31:0] m_dout, m_din;
    logic        busy, interrupt;

    logic        gate, m0_req, g0;
    logic [31:0] wmem [0:65535];
    int          total = 0;
    int          bad = 0;
    int          req_cnt = 0;

    typedef struct packed {
        logic [15:0] a;
        logic [31:0] d;
    } xfer_t;
    xfer_t exp_q[$];

    always #5 clk = ~clk;

    dma_ctrl #(.ADDR_W(16), .DATA_W(32), .CNT_W(4)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_sel    (s_sel),
        .s_wr     (s_wr),
        .s_addr   (s_addr),
        .s_din    (s_din),
        .s_dout   (s_dout),
        .m_req    (m_req),
        .m_grant  (m_grant),
        .m_wr     (m_wr),
        .m_addr   (m_addr),
        .m_dout   (m_dout),
        .m_din    (m_din),
        .busy     (busy),
        .interrupt(interrupt)
    );

    // Source memory content is a fixed pattern of the address.
    function automatic logic [31:0] pat(input logic [15:0] a);
        return {16'hD5A0, a};
    endfunction

    assign m_din = pat(m_addr);

    always @(posedge clk) begin
        if (m_wr && m_grant) wmem[m_addr] <= m_dout;
    end

    // Two-master arbiter model: master 0 gets single-cycle slots.
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_grant <= 1'b0;
            g0      <= 1'b0;
        end else if (m_grant && m_req && gate) begin
            m_grant <= 1'b1;
            g0      <= 1'b0;
        end else if (m0_req && !g0) begin
            m_grant <= 1'b0;
            g0      <= 1'b1;
        end else begin
            m_grant <= m_req && gate;
            g0      <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            if (m_req) req_cnt++;
            if (m_req && !m_grant) begin
                total++;
                if (m_wr) begin
                    bad++;
                    $display("FAIL stall_access: m_wr=%0b while ungranted, want 0", m_wr);
                end
            end
            if (m_wr && m_grant) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL extra_write: addr=0x%0h data=0x%0h, none expected", m_addr, m_dout);
                end else begin
                    xfer_t e;
                    e = exp_q.pop_front();
                    if (m_addr !== e.a || m_dout !== e.d) begin
                        bad++;
                        $display("FAIL bus_write: got addr=0x%0h data=0x%0h want addr=0x%0h data=0x%0h",
                                 m_addr, m_dout, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        @(posedge clk);
        #1;
        s_sel = 1'b0; s_wr = 1'b0; s_din = '0;
    endtask

    task automatic reg_rd(input string name, input logic [1:0] a, input logic [31:0] exp);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
        #1;
        chk(name, s_dout, exp);
        s_sel = 1'b0;
    endtask

    task automatic start_xfer(input logic [15:0] src, input logic [15:0] dst, input int n);
        reg_wr(REG_SRC, 32'(src));
        reg_wr(REG_DST, 32'(dst));
        reg_wr(REG_SIZE, 32'(n));
        for (int i = 0; i < n; i++) begin
            exp_q.push_back('{a: dst + 16'(i), d: pat(src + 16'(i))});
        end
        reg_wr(REG_CTRL, 32'h1);
    endtask

    task automatic wait_irq(output int edges, output int busy_cyc);
        edges = 1;
        busy_cyc = busy ? 1 : 0;
        while (!interrupt && edges < 300) begin
            @(posedge clk);
            #1;
            edges++;
            if (busy) busy_cyc++;
        end
        chk("irq_seen", 32'(interrupt), 32'h1);
    endtask

    task automatic wait_write(input string name);
        int k = 0;
        @(negedge clk);
        while (!(m_wr && m_grant) && k < 100) begin
            @(negedge clk);
            k++;
        end
        chk(name, 32'(k < 100), 32'h1);
    endtask

    task automatic clear_irq();
        reg_wr(REG_CTRL, 32'h2);
        chk("irq_clear", 32'(interrupt), 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int edges, bcyc, rc, lowc, g0c;
        reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = '0; s_din = '0;
        gate = 1'b1; m0_req = 1'b0;
        #1;
        chk("rst_outs", {26'd0, m_req, m_wr, busy, interrupt, |m_addr, |m_dout}, 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        reg_rd("rst_ctrl", REG_CTRL, 32'h0);
        reg_rd("rst_src", REG_SRC, 32'h0);

        // Basic 3-word copy with immediate grant
        start_xfer(16'h0010, 16'h0080, 3);
        wait_irq(edges, bcyc);
`ifndef DMA_CTRL_RELEASE_EN
        chk("t1_irq_edge", 32'(edges), 32'd10);
        chk("t1_busy_cycles", 32'(bcyc), 32'd9);
`endif
        reg_rd("t1_ctrl_rd", REG_CTRL, 32'h1);
        chk("t1_sb_empty", 32'(exp_q.size()), 32'h0);
        clear_irq();

        // SIZE=0 completes without touching the bus
        rc = req_cnt;
        reg_wr(REG_SIZE, 32'h0);
        reg_wr(REG_CTRL, 32'h1);
        chk("t2_busy_t1", 32'(busy), 32'h1);
        chk("t2_irq_t1", 32'(interrupt), 32'h0);
        @(posedge clk); #1;
        chk("t2_irq_t2", 32'(interrupt), 32'h1);
        chk("t2_busy_t2", 32'(busy), 32'h0);
        repeat (3) @(posedge clk);
        chk("t2_no_req", 32'(req_cnt - rc), 32'h0);
        clear_irq();

        // Grant withheld, then dropped during a WRITE
        gate = 1'b0;
        start_xfer(16'h0300, 16'h0380, 4);
        repeat (5) @(posedge clk);
        #1;
        chk("t3_req_waiting", {30'd0, m_req, m_grant}, 32'h2);
        gate = 1'b1;
        wait_write("t3_first_write");
        @(posedge clk);
        @(negedge clk) gate = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk) gate = 1'b1;
        wait_irq(edges, bcyc);
        for (int i = 0; i < 4; i++) begin
            chk("t3_image", wmem[16'h0380 + 16'(i)], pat(16'h0300 + 16'(i)));
        end
        chk("t3_sb_empty", 32'(exp_q.size()), 32'h0);
        clear_irq();

        // Source address wraps past 0xFFFF
        start_xfer(16'hFFFF, 16'h0400, 2);
        wait_irq(edges, bcyc);
        chk("t4_wrap_word1", wmem[16'h0401], 32'hD5A0_0000);
        chk("t4_sb_empty", 32'(exp_q.size()), 32'h0);
        clear_irq();

        // Register writes and START while busy are ignored
        start_xfer(16'h0200, 16'h0500, 3);
        reg_wr(REG_SRC, 32'h1234);
        reg_wr(REG_CTRL, 32'h1);
        wait_irq(edges, bcyc);
        reg_rd("t5_src_kept", REG_SRC, 32'h0200);
        chk("t5_sb_empty", 32'(exp_q.size()), 32'h0);
        clear_irq();
        repeat (3) @(posedge clk);
        #1;
        chk("t5_no_restart", 32'(busy), 32'h0);

        // Reset during the second READ
        start_xfer(16'h0600, 16'h0700, 3);
        wait_write("t6_first_write");
        @(posedge clk); #1;
        chk("t6_read2_addr", 32'(m_addr), 32'h0601);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_outs", {26'd0, m_req, m_wr, busy, interrupt, |m_addr, |m_dout}, 32'h0);
        exp_q.delete();
        @(negedge clk) reset_n = 1'b1;
        reg_rd("t6_src_cleared", REG_SRC, 32'h0);
        start_xfer(16'h0610, 16'h0710, 2);
        wait_irq(edges, bcyc);
        chk("t6_sb_empty", 32'(exp_q.size()), 32'h0);
        clear_irq();

`ifdef DMA_CTRL_RELEASE_EN
        // Master 0 gets a slot between words
        m0_req = 1'b1;
        lowc = 0;
        g0c = 0;
        start_xfer(16'h0800, 16'h0900, 3);
        for (int k = 0; k < 200 && !interrupt; k++) begin
            if (busy && !m_req) lowc++;
            if (busy && g0) g0c++;
            @(posedge clk); #1;
        end
        m0_req = 1'b0;
        chk("t7_req_low_cycles", 32'(lowc), 32'd3);
        chk("t7_m0_slots", 32'(g0c >= 2), 32'h1);
        chk("t7_sb_empty", 32'(exp_q.size()), 32'h0);
        clear_irq();
`else
        lowc = 0;
        g0c = 0;
`endif

        chk("final_sb_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
